// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result path: default widths, write-back
// state encoding and the requantisation helper.
package tpu_pkg;

    localparam int unsigned ACC_WIDTH = 32;
    localparam int unsigned OUT_WIDTH = 16;
    localparam int unsigned DATASET_W = 2;

    localparam logic [1:0] WB_IDLE   = 2'd0;
    localparam logic [1:0] WB_ACTIVE = 2'd1;
    localparam logic [1:0] WB_DRAIN  = 2'd2;
    localparam logic [1:0] WB_DONE   = 2'd3;

    // Arithmetic right shift, then clamp to a signed out_w-bit range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int unsigned        shift,
        input int unsigned        out_w
    );
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        q  = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        res = q;
        if (q > hi) begin
            res = hi;
        end else if (q < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_row_fifo.sv
// Row buffer between the quantiser and the output SRAM port; the head entry
// is read straight from registered storage.
module wb_row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/systolic_result_writeback.sv
// Captures result rows from the systolic array, requantises them, buffers them
// and writes them to the output SRAM, then signals end of job write-back.
module systolic_result_writeback #(
    parameter int unsigned ARRAY_SIZE = 32,
    parameter int unsigned ACC_WIDTH  = tpu_pkg::ACC_WIDTH,
    parameter int unsigned OUT_WIDTH  = tpu_pkg::OUT_WIDTH,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_WIDTH  = $clog2(ARRAY_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 row_wr_en,
    input  logic [IDX_WIDTH-1:0]                 matrix_index,
    input  logic [tpu_pkg::DATASET_W-1:0]        data_set,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]      row_data,
    input  logic                                 tpu_done,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [IDX_WIDTH+1:0]                 out_addr,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0]      out_data,
    output logic [IDX_WIDTH+2:0]                 rows_written,
    output logic                                 overflow,
    output logic                                 wb_done,
    output logic                                 busy
);

    import tpu_pkg::*;

    localparam int unsigned ADDR_W  = IDX_WIDTH + DATASET_W;
    localparam int unsigned ROW_W   = ARRAY_SIZE * OUT_WIDTH;
    localparam int unsigned ENTRY_W = ADDR_W + ROW_W;
    localparam int unsigned CNT_W   = IDX_WIDTH + 3;

    logic [ROW_W-1:0]   quant_row;
    logic               s1_valid_q;
    logic [ADDR_W-1:0]  s1_addr_q;
    logic [ROW_W-1:0]   s1_data_q;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               row_drop;
    logic [ENTRY_W-1:0] fifo_head;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   rows_written_q, rows_written_d;
    logic               overflow_q, overflow_d;
    logic               wb_done_q, wb_done_d;
    logic               busy_q, busy_d;
    logic               job_start;

    // Per-element requantisation of the incoming accumulator row.
    for (genvar i = 0; i < int'(ARRAY_SIZE); i++) begin : g_quant
        logic signed [ACC_WIDTH-1:0] acc;
        assign acc = row_data[i*ACC_WIDTH +: ACC_WIDTH];
        assign quant_row[i*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(sat_shift(64'(acc), SHIFT, OUT_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= row_wr_en;
            if (row_wr_en) begin
                s1_addr_q <= {data_set, matrix_index};
                s1_data_q <= quant_row;
            end
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign fifo_pop  = !fifo_empty && out_ready;
    assign fifo_push = s1_valid_q && (!fifo_full || fifo_pop);
    assign row_drop  = s1_valid_q && fifo_full && !fifo_pop;

    wb_row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({s1_addr_q, s1_data_q}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WB_IDLE;
            rows_written_q <= '0;
            overflow_q     <= 1'b0;
            wb_done_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rows_written_q <= rows_written_d;
            overflow_q     <= overflow_d;
            wb_done_q      <= wb_done_d;
            busy_q         <= busy_d;
        end
    end

    // Job sequencing plus the per-job counters, which reset on job entry.
    always_comb begin
        state_d   = state_q;
        job_start = 1'b0;
        case (state_q)
            WB_IDLE: begin
                job_start = row_wr_en;
                if (tpu_done) begin
                    state_d = WB_DRAIN;
                end else if (row_wr_en) begin
                    state_d = WB_ACTIVE;
                end
            end
            WB_ACTIVE: begin
                if (tpu_done) begin
                    state_d = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                if (!s1_valid_q && fifo_empty && !row_wr_en) begin
                    state_d = WB_DONE;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        rows_written_d = rows_written_q;
        if (job_start) begin
            rows_written_d = '0;
        end else if (fifo_pop && (rows_written_q != '1)) begin
            rows_written_d = rows_written_q + CNT_W'(1);
        end

        overflow_d = job_start ? 1'b0 : overflow_q;
        if (row_drop) begin
            overflow_d = 1'b1;
        end

        wb_done_d = (state_d == WB_DONE);
        busy_d    = (state_d != WB_IDLE);
    end

    assign out_valid    = !fifo_empty;
    assign out_addr     = fifo_head[ENTRY_W-1 -: ADDR_W];
    assign out_data     = fifo_head[ROW_W-1:0];
    assign rows_written = rows_written_q;
    assign overflow     = overflow_q;
    assign wb_done      = wb_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_systolic_result_writeback.sv
// Directed bench for systolic_result_writeback with a queue-based reference
// model compared every cycle plus hand-computed literal expectations.
module tb_systolic_result_writeback;

    localparam int AS    = 32;
    localparam int AW    = 32;
    localparam int OW    = 16;
    localparam int DEPTH = 4;
    localparam int IW    = 5;
    localparam int ADW   = IW + 2;
    localparam int CW    = IW + 3;
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2, M_DONE = 3;

    typedef struct packed {
        logic [ADW-1:0]   addr;
        logic [AS*OW-1:0] data;
    } row_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              row_wr_en = 1'b0;
    logic [IW-1:0]     matrix_index = '0;
    logic [1:0]        data_set = '0;
    logic [AS*AW-1:0]  row_data = '0;
    logic              tpu_done = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADW-1:0]    out_addr;
    logic [AS*OW-1:0]  out_data;
    logic [CW-1:0]     rows_written;
    logic              overflow;
    logic              wb_done;
    logic              busy;

    always #5 clk = ~clk;

    systolic_result_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .row_wr_en    (row_wr_en),
        .matrix_index (matrix_index),
        .data_set     (data_set),
        .row_data     (row_data),
        .tpu_done     (tpu_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .rows_written (rows_written),
        .overflow     (overflow),
        .wb_done      (wb_done),
        .busy         (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [AS*OW-1:0] act, input logic [AS*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference requantisation: arithmetic shift by 8 then clamp to int16.
    function automatic logic [OW-1:0] q16(input logic [AW-1:0] a);
        longint v;
        v = longint'($signed(a));
        v = v >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[OW-1:0];
    endfunction

    function automatic logic [AS*OW-1:0] quant_row(input logic [AS*AW-1:0] d);
        logic [AS*OW-1:0] r;
        for (int j = 0; j < AS; j++) r[j*OW +: OW] = q16(d[j*AW +: AW]);
        return r;
    endfunction

    function automatic logic [AS*AW-1:0] pattern(input int idx, input int ds);
        logic [AS*AW-1:0] d;
        logic [31:0] e;
        for (int j = 0; j < AS; j++) begin
            e = 32'(idx) * 32'h01234567 + 32'(j) * 32'h00F1E2D3 + 32'(ds) * 32'h3C000000;
            d[j*AW +: AW] = e;
        end
        return d;
    endfunction

    // Reference model state
    row_t mq[$];
    logic ms1v = 1'b0;
    row_t ms1 = '0;
    int   mstate = M_IDLE;
    int   mcnt = 0;
    logic movf = 1'b0, mwbd = 1'b0, mbusy = 1'b0;
    bit   m_pop, m_full, m_empty, m_start;
    int   m_next;
    int   cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            ms1v = 1'b0; mstate = M_IDLE; mcnt = 0;
            movf = 1'b0; mwbd = 1'b0; mbusy = 1'b0;
        end else begin
            m_empty = (mq.size() == 0);
            m_full  = (mq.size() == DEPTH);
            m_pop   = !m_empty && out_ready;
            m_start = (mstate == M_IDLE) && row_wr_en;
            m_next  = mstate;
            case (mstate)
                M_IDLE:   if (tpu_done) m_next = M_DRAIN; else if (row_wr_en) m_next = M_ACTIVE;
                M_ACTIVE: if (tpu_done) m_next = M_DRAIN;
                M_DRAIN:  if (!ms1v && m_empty && !row_wr_en) m_next = M_DONE;
                default:  m_next = M_IDLE;
            endcase
            if (m_pop) void'(mq.pop_front());
            if (m_start) mcnt = 0;
            else if (m_pop && mcnt < 255) mcnt++;
            if (m_start) movf = 1'b0;
            if (ms1v) begin
                if (!m_full || m_pop) mq.push_back(ms1);
                else movf = 1'b1;
            end
            ms1v = row_wr_en;
            if (row_wr_en) begin
                ms1.addr = {data_set, matrix_index};
                ms1.data = quant_row(row_data);
            end
            mstate = m_next;
            mwbd   = (m_next == M_DONE);
            mbusy  = (m_next != M_IDLE);
        end
    end

    int hs_count = 0, wb_count = 0, last_hs_cyc = 0, wb_cyc = 0;

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_addr", 32'(out_addr), 32'(mq[0].addr));
            chkd("out_data", out_data, mq[0].data);
        end
        chk("rows_written", 32'(rows_written), 32'(mcnt));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("wb_done", 32'(wb_done), 32'(mwbd));
        chk("busy", 32'(busy), 32'(mbusy));
        if (out_valid && out_ready) begin hs_count++; last_hs_cyc = cyc; end
        if (wb_done) begin wb_count++; wb_cyc = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input int ds, input logic [AS*AW-1:0] d);
        row_wr_en    = 1'b1;
        matrix_index = IW'(idx);
        data_set     = 2'(ds);
        row_data     = d;
        tick();
        row_wr_en = 1'b0;
    endtask

    task automatic finish_job();
        bit seen;
        seen = 1'b0;
        out_ready = 1'b1;
        tpu_done  = 1'b1;
        tick();
        tpu_done = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (wb_done) seen = 1'b1;
            else tick();
        end
        chk("wb_done_timeout", 32'(seen), 32'd1);
        tick();
    endtask

    logic [AS*AW-1:0] qd;
    int hs0, wb0;
    bit seen;

    initial begin
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rows", 32'(rows_written), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chkd("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();

        // Quantisation and N+2 latency
        for (int j = 0; j < AS; j++) qd[j*AW +: AW] = 32'hFFFFFED4;
        qd[31:0]  = 32'h00012345;
        qd[63:32] = 32'h7FFFFFFF;
        qd[95:64] = 32'h80000000;
        out_ready = 1'b1;
        send(3, 1, qd);
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("q_elem0", 32'(out_data[15:0]), 32'h0123);
        chk("q_elem1", 32'(out_data[31:16]), 32'h7FFF);
        chk("q_elem2", 32'(out_data[47:32]), 32'h8000);
        chk("q_elem3", 32'(out_data[63:48]), 32'hFFFE);
        chk("q_addr", 32'(out_addr), 32'h23);
        tick();
        finish_job();

        // Streaming 32 rows
        hs0 = hs_count;
        for (int i = 0; i < AS; i++) begin
            send(i, 0, pattern(i, 0));
            if (i == 1) chk("stream_first_valid", 32'(out_valid), 32'd1);
        end
        tick(); tick(); tick();
        chk("stream_rows", 32'(rows_written), 32'd32);
        chk("stream_ovf", 32'(overflow), 32'd0);
        chk("stream_hs", 32'(hs_count - hs0), 32'd32);
        finish_job();

        // Backpressure: 6 rows into a depth-4 FIFO with the sink stalled
        out_ready = 1'b0;
        hs0 = hs_count;
        for (int i = 0; i < 6; i++) send(i, 2, pattern(i, 2));
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_head_addr", 32'(out_addr), 32'h40);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_rows", 32'(rows_written), 32'd5);
        chk("bp_hs", 32'(hs_count - hs0), 32'd5);
        finish_job();

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) out_ready = 1'b1;
            send(i, 3, pattern(i, 3));
        end
        for (int i = 0; i < 6; i++) tick();
        chk("pp_overflow", 32'(overflow), 32'd0);
        chk("pp_rows", 32'(rows_written), 32'd12);
        finish_job();

        // Done with rows still buffered and a toggling sink
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(i + 7, 1, pattern(i + 7, 1));
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
        wb0 = wb_count;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            out_ready = (k % 2 == 0);
            tick();
            seen = wb_done;
        end
        chk("done_seen", 32'(seen), 32'd1);
        tick();
        chk("done_busy_fall", 32'(busy), 32'd0);
        chk("done_one_pulse", 32'(wb_count - wb0), 32'd1);
        chk("done_after_hs", 32'(wb_cyc > last_hs_cyc), 32'd1);
        chk("done_rows", 32'(rows_written), 32'd3);
        tick(); tick();
        chk("done_no_repeat", 32'(wb_count - wb0), 32'd1);

        // Reset mid-job with rows buffered
        out_ready = 1'b0;
        send(1, 0, pattern(1, 0));
        send(2, 0, pattern(2, 0));
        tick();
        wb0 = wb_count;
        rst = 1'b1;
        tick();
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_rows", 32'(rows_written), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mrst_no_wb_done", 32'(wb_count - wb0), 32'd0);
        chk("mrst_still_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
